// File: rtl/sdram_wb_arbiter.sv
// Two-master Wishbone arbiter (m0 = instruction fetch, m1 = data) in front of a single-port SDRAM slave.
// Define SDRAM_ARB_RR_EN for round-robin on simultaneous requests; default build gives m1 fixed priority.
module sdram_wb_arbiter #(
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned TMR_W   = 16
) (
  input  logic        clk_sys,
  input  logic        rst_n_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RELEASE} state_t;

  localparam bit               TMO_EN   = (TIMEOUT != 0);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [TMR_W-1:0]  r_timer;
  logic              r_rel_wait;
  logic [1:0]        r_grant;
  logic              r_s_cyc;
  logic              r_s_we;
  logic [3:0]        r_s_sel;
  logic [31:0]       r_s_adr;
  logic [31:0]       r_s_dat;
  logic [31:0]       r_m0_dat;
  logic [31:0]       r_m1_dat;
  logic              r_m0_ack;
  logic              r_m1_ack;
  logic              r_m0_err;
  logic              r_m1_err;

  logic              w_req0;
  logic              w_req1;
  logic              w_win_m1;
  logic              w_start;
  logic              w_done_ack;
  logic              w_done_tmo;
  logic              w_rel_exit;

  assign w_req0 = m0_cyc_i & m0_stb_i;
  assign w_req1 = m1_cyc_i & m1_stb_i;

`ifdef SDRAM_ARB_RR_EN
  logic r_last_grant;  // 1 = m1 was the previous owner

  // On a tie the master that did not own the slave last time wins.
  assign w_win_m1 = w_req1 & (~w_req0 | ~r_last_grant);

  always_ff @(posedge clk_sys or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_last_grant <= 1'b1;
    end else if (w_rel_exit) begin
      r_last_grant <= r_grant[1];
    end
  end
`else
  assign w_win_m1 = w_req1;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_done_ack  = 1'b0;
    w_done_tmo  = 1'b0;
    w_rel_exit  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_req0 | w_req1) begin
          w_start     = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (s_ack_i) begin
          w_done_ack  = 1'b1;
          w_state_nxt = ST_RELEASE;
        end else if (TMO_EN && (r_timer == TMO_LAST)) begin
          w_done_tmo  = 1'b1;
          w_state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // The slave keeps ack up until it sees cyc low; wait it out plus one settle cycle.
        if (r_rel_wait && !s_ack_i) begin
          w_rel_exit  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= ST_IDLE;
      r_timer    <= '0;
      r_rel_wait <= 1'b0;
      r_grant    <= 2'b00;
      r_s_cyc    <= 1'b0;
      r_s_we     <= 1'b0;
      r_s_sel    <= '0;
      r_s_adr    <= '0;
      r_s_dat    <= '0;
      r_m0_dat   <= '0;
      r_m1_dat   <= '0;
      r_m0_ack   <= 1'b0;
      r_m1_ack   <= 1'b0;
      r_m0_err   <= 1'b0;
      r_m1_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here updates from pre-edge values.
      r_state  <= w_state_nxt;
      r_m0_ack <= 1'b0;
      r_m1_ack <= 1'b0;
      r_m0_err <= 1'b0;
      r_m1_err <= 1'b0;

      if (w_start) begin
        r_s_cyc <= 1'b1;
        r_s_we  <= w_win_m1 ? m1_we_i  : m0_we_i;
        r_s_sel <= w_win_m1 ? m1_sel_i : m0_sel_i;
        r_s_adr <= w_win_m1 ? m1_adr_i : m0_adr_i;
        r_s_dat <= w_win_m1 ? m1_dat_i : m0_dat_i;
        r_grant <= w_win_m1 ? 2'b10 : 2'b01;
        r_timer <= '0;
      end else if (r_state == ST_BUSY) begin
        r_timer <= r_timer + TMR_W'(1);
      end

      if (w_done_ack || w_done_tmo) begin
        r_s_cyc    <= 1'b0;
        r_rel_wait <= 1'b0;
      end

      if (w_done_ack) begin
        r_m0_ack <= r_grant[0];
        r_m1_ack <= r_grant[1];
        if (!r_s_we) begin
          if (r_grant[1]) r_m1_dat <= s_dat_i;
          else            r_m0_dat <= s_dat_i;
        end
      end

      if (w_done_tmo) begin
        r_m0_err <= r_grant[0];
        r_m1_err <= r_grant[1];
      end

      if (r_state == ST_RELEASE) r_rel_wait <= 1'b1;
      if (w_rel_exit)            r_grant    <= 2'b00;
    end
  end

  assign s_cyc_o  = r_s_cyc;
  assign s_stb_o  = r_s_cyc;
  assign s_we_o   = r_s_we;
  assign s_sel_o  = r_s_sel;
  assign s_adr_o  = r_s_adr;
  assign s_dat_o  = r_s_dat;
  assign grant_o  = r_grant;
  assign m0_dat_o = r_m0_dat;
  assign m1_dat_o = r_m1_dat;
  assign m0_ack_o = r_m0_ack;
  assign m1_ack_o = r_m1_ack;
  assign m0_err_o = r_m0_err;
  assign m1_err_o = r_m1_err;

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Self-checking bench for sdram_wb_arbiter: slave model, per-master response scoreboard, grant log.
// Expectations follow SDRAM_ARB_RR_EN when the bench is built with it defined.
module tb_sdram_wb_arbiter;

  localparam int unsigned TMO    = 20;
  localparam logic [31:0] RD_KEY = 32'hA5A5_5A5A;

  logic        clk_sys = 1'b0;
  logic        rst_n   = 1'b0;
  logic        m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i;
  logic [1:0]  grant_o;

  typedef struct packed {
    logic        err;
    logic [31:0] dat;
  } resp_t;

  resp_t       exp0[$];
  resp_t       exp1[$];
  logic [31:0] mdl_dat [2];
  logic [1:0]  grant_log[$];
  int          vectors     = 0;
  int          miscompares = 0;

  // Slave model controls
  int          slv_lat   = 8;
  int          slv_hold  = 0;
  logic        slv_never = 1'b0;
  logic        slv_fixed = 1'b0;
  logic [31:0] slv_rdata = 32'h0;
  int          s_cnt;
  int          h_cnt;

  logic [1:0]  w_ack, w_err;
  logic [31:0] w_dato [2];
  assign w_ack     = {m1_ack_o, m0_ack_o};
  assign w_err     = {m1_err_o, m0_err_o};
  assign w_dato[0] = m0_dat_o;
  assign w_dato[1] = m1_dat_o;

  always #5 clk_sys = ~clk_sys;

  sdram_wb_arbiter #(.TIMEOUT(TMO), .TMR_W(16)) dut (
    .clk_sys  (clk_sys),
    .rst_n_i  (rst_n),
    .m0_cyc_i (m0_cyc_i), .m0_stb_i (m0_stb_i), .m0_we_i (m0_we_i), .m0_sel_i (m0_sel_i),
    .m0_adr_i (m0_adr_i), .m0_dat_i (m0_dat_i), .m0_dat_o (m0_dat_o),
    .m0_ack_o (m0_ack_o), .m0_err_o (m0_err_o),
    .m1_cyc_i (m1_cyc_i), .m1_stb_i (m1_stb_i), .m1_we_i (m1_we_i), .m1_sel_i (m1_sel_i),
    .m1_adr_i (m1_adr_i), .m1_dat_i (m1_dat_i), .m1_dat_o (m1_dat_o),
    .m1_ack_o (m1_ack_o), .m1_err_o (m1_err_o),
    .s_cyc_o  (s_cyc_o), .s_stb_o (s_stb_o), .s_we_o (s_we_o), .s_sel_o (s_sel_o),
    .s_adr_o  (s_adr_o), .s_dat_o (s_dat_o), .s_dat_i (s_dat_i), .s_ack_i (s_ack_i),
    .grant_o  (grant_o)
  );

  // Slave: ack after slv_lat cycles of cyc, hold ack slv_hold extra cycles after cyc drops.
  always @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      s_ack_i <= 1'b0;
      s_dat_i <= 32'h0;
      s_cnt   <= 0;
      h_cnt   <= 0;
    end else if (s_cyc_o && !s_ack_i) begin
      h_cnt <= 0;
      if (!slv_never) begin
        if (s_cnt >= slv_lat - 1) begin
          s_ack_i <= 1'b1;
          s_dat_i <= slv_fixed ? slv_rdata : (s_adr_o ^ RD_KEY);
          s_cnt   <= 0;
        end else begin
          s_cnt <= s_cnt + 1;
        end
      end
    end else if (!s_cyc_o && s_ack_i) begin
      if (h_cnt >= slv_hold) s_ack_i <= 1'b0;
      else                   h_cnt   <= h_cnt + 1;
    end
  end

  // Scoreboard monitor: pops one expectation per ack/err pulse; logs each new grant.
  logic [1:0] prev_resp;
  logic [1:0] prev_grant;
  resp_t      mon_e;
  logic       mon_have;

  always @(negedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      prev_resp  <= 2'b00;
      prev_grant <= 2'b00;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (w_ack[p] | w_err[p]) begin
          vectors++;
          mon_have = (p == 0) ? (exp0.size() != 0) : (exp1.size() != 0);
          if (!mon_have) begin
            miscompares++;
            $display("FAIL m%0d_resp: unexpected response ack=%b err=%b, want none", p, w_ack[p], w_err[p]);
          end else begin
            if (p == 0) mon_e = exp0.pop_front();
            else        mon_e = exp1.pop_front();
            if (w_ack[p] !== ~mon_e.err || w_err[p] !== mon_e.err || w_dato[p] !== mon_e.dat) begin
              miscompares++;
              $display("FAIL m%0d_resp: got ack=%b err=%b dat=%h, want ack=%b err=%b dat=%h",
                       p, w_ack[p], w_err[p], w_dato[p], ~mon_e.err, mon_e.err, mon_e.dat);
            end
          end
        end
        if (prev_resp[p]) begin
          vectors++;
          if (w_ack[p] | w_err[p]) begin
            miscompares++;
            $display("FAIL m%0d_pulse: response high 2 cycles, want 1", p);
          end
        end
      end
      if (grant_o != 2'b00 && prev_grant == 2'b00) grant_log.push_back(grant_o);
      prev_resp  <= w_ack | w_err;
      prev_grant <= grant_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got hang, want completion");
    $fatal(1);
  end

  task automatic idle_inputs();
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = '0; m0_adr_i = '0; m0_dat_i = '0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = '0; m1_adr_i = '0; m1_dat_i = '0;
  endtask

  task automatic drive_m(input int p, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
    if (p == 0) begin
      m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = we; m0_adr_i = adr; m0_dat_i = dat; m0_sel_i = sel;
    end else begin
      m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = we; m1_adr_i = adr; m1_dat_i = dat; m1_sel_i = sel;
    end
  endtask

  task automatic drop_m(input int p);
    if (p == 0) begin m0_cyc_i = 0; m0_stb_i = 0; end
    else        begin m1_cyc_i = 0; m1_stb_i = 0; end
  endtask

  // Push the dat_o value the master must show once its transfer completes.
  task automatic expect_resp(input int p, input logic is_read, input logic err, input logic [31:0] rd);
    resp_t e;
    if (is_read && !err) mdl_dat[p] = rd;
    e.err = err;
    e.dat = mdl_dat[p];
    if (p == 0) exp0.push_back(e);
    else        exp1.push_back(e);
  endtask

  task automatic wait_resp(input int p, input int max);
    vectors++;
    for (int i = 0; i < max; i++) begin
      @(negedge clk_sys);
      if (w_ack[p] | w_err[p]) return;
    end
    miscompares++;
    $display("FAIL m%0d_wait: no response in %0d cycles, want ack or err", p, max);
  endtask

  task automatic wait_idle(input int max);
    vectors++;
    for (int i = 0; i < max; i++) begin
      @(negedge clk_sys);
      if (grant_o == 2'b00 && !s_cyc_o) return;
    end
    miscompares++;
    $display("FAIL wait_idle: grant=%b cyc=%b after %0d cycles, want 00/0", grant_o, s_cyc_o, max);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #12;
    vectors++;
    if ({s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o} !== 71'd0) begin
      miscompares++;
      $display("FAIL reset_slave: got cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h, want all 0",
               s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o);
    end
    vectors++;
    if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, m0_dat_o, m1_dat_o} !== 68'd0) begin
      miscompares++;
      $display("FAIL reset_master: got ack=%b%b err=%b%b dat0=%h dat1=%h, want all 0",
               m1_ack_o, m0_ack_o, m1_err_o, m0_err_o, m0_dat_o, m1_dat_o);
    end
    vectors++;
    if (grant_o !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_grant: got %b, want 00", grant_o);
    end
    @(negedge clk_sys);
    rst_n = 1;
    repeat (3) @(negedge clk_sys);
    vectors++;
    if ({s_cyc_o, grant_o} !== 3'b000) begin
      miscompares++;
      $display("FAIL idle_quiet: got cyc=%b grant=%b, want 0/00", s_cyc_o, grant_o);
    end
  endtask

  task automatic test_single_read();
    slv_fixed = 1; slv_rdata = 32'hDEAD_BEEF; slv_lat = 8; slv_hold = 0;
    @(negedge clk_sys);
    expect_resp(0, 1, 0, 32'hDEAD_BEEF);
    drive_m(0, 0, 32'h0000_0100, 32'h0, 4'hF);
    @(negedge clk_sys);
    vectors++;
    if ({s_cyc_o, s_stb_o, s_we_o, s_adr_o, grant_o} !== {1'b1, 1'b1, 1'b0, 32'h100, 2'b01}) begin
      miscompares++;
      $display("FAIL read_issue: got cyc=%b stb=%b we=%b adr=%h grant=%b, want 1/1/0/00000100/01",
               s_cyc_o, s_stb_o, s_we_o, s_adr_o, grant_o);
    end
    wait_resp(0, 40);
    drop_m(0);
    @(negedge clk_sys);
    vectors++;
    if (m0_ack_o !== 1'b0 || m0_dat_o !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL read_after: got ack=%b dat=%h, want 0/deadbeef", m0_ack_o, m0_dat_o);
    end
    wait_idle(10);
    slv_fixed = 0;
  endtask

  task automatic test_write_hold();
    logic got;
    int   extra;
    slv_lat = 6;
    got = 0;
    @(negedge clk_sys);
    expect_resp(1, 0, 0, 32'h0);
    drive_m(1, 1, 32'h0000_0200, 32'h1234_5678, 4'b0011);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_sys);
      if (s_cyc_o) begin
        vectors++;
        if ({s_we_o, s_sel_o, s_adr_o, s_dat_o} !== {1'b1, 4'b0011, 32'h200, 32'h1234_5678}) begin
          miscompares++;
          $display("FAIL write_hold: got we=%b sel=%b adr=%h dat=%h, want 1/0011/00000200/12345678",
                   s_we_o, s_sel_o, s_adr_o, s_dat_o);
        end
      end
      if (i == 2) begin
        m1_adr_i = 32'h0000_0300; m1_dat_i = 32'hCAFE_F00D; m1_sel_i = 4'b1100;
      end
      if (m1_ack_o | m1_err_o) begin
        got = 1;
        break;
      end
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL write_done: got no response, want m1 ack");
    end
    drop_m(1);
    extra = 0;
    repeat (4) begin
      @(negedge clk_sys);
      if (m1_ack_o | m1_err_o) extra++;
    end
    vectors++;
    if (extra != 0) begin
      miscompares++;
      $display("FAIL write_once: got %0d extra responses, want 0", extra);
    end
    wait_idle(10);
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g [4];
    int         n;
    slv_lat = 2;
    grant_log.delete();
`ifdef SDRAM_ARB_RR_EN
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    expect_resp(0, 1, 0, 32'h1000 ^ RD_KEY);
    expect_resp(1, 1, 0, 32'h2000 ^ RD_KEY);
    expect_resp(0, 1, 0, 32'h1000 ^ RD_KEY);
    expect_resp(1, 1, 0, 32'h2000 ^ RD_KEY);
`else
    exp_g = '{2'b10, 2'b10, 2'b10, 2'b10};
    for (int k = 0; k < 4; k++) expect_resp(1, 1, 0, 32'h2000 ^ RD_KEY);
`endif
    @(negedge clk_sys);
    drive_m(0, 0, 32'h0000_1000, 32'h0, 4'hF);
    drive_m(1, 0, 32'h0000_2000, 32'h0, 4'hF);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_sys);
      if (m0_ack_o | m0_err_o) n++;
      if (m1_ack_o | m1_err_o) n++;
      if (n >= 4) break;
    end
    drop_m(0);
    drop_m(1);
    vectors++;
    if (n != 4) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d completions, want 4", n);
    end
    wait_idle(10);
    vectors++;
    if (grant_log.size() != 4) begin
      miscompares++;
      $display("FAIL b2b_grants: got %0d grants, want 4", grant_log.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (grant_log[k] !== exp_g[k]) begin
          miscompares++;
          $display("FAIL b2b_grant%0d: got %b, want %b", k, grant_log[k], exp_g[k]);
        end
      end
    end
    vectors++;
    if (exp0.size() + exp1.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_pending: got %0d/%0d outstanding, want 0/0", exp0.size(), exp1.size());
    end
  endtask

  task automatic test_ack_hold();
    slv_lat = 3; slv_hold = 3;
    @(negedge clk_sys);
    expect_resp(1, 1, 0, 32'h40 ^ RD_KEY);
    drive_m(1, 0, 32'h0000_0040, 32'h0, 4'hF);
    @(negedge clk_sys);
    expect_resp(0, 1, 0, 32'h80 ^ RD_KEY);
    drive_m(0, 0, 32'h0000_0080, 32'h0, 4'hF);
    wait_resp(1, 40);
    drop_m(1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_sys);
      if (!s_ack_i) break;
      vectors++;
      if ({s_cyc_o, grant_o} !== 3'b010) begin
        miscompares++;
        $display("FAIL hold_release: got cyc=%b grant=%b while slave ack high, want 0/10", s_cyc_o, grant_o);
      end
    end
    @(negedge clk_sys);
    vectors++;
    if ({s_cyc_o, grant_o} !== 3'b000) begin
      miscompares++;
      $display("FAIL hold_idle: got cyc=%b grant=%b, want 0/00", s_cyc_o, grant_o);
    end
    @(negedge clk_sys);
    vectors++;
    if ({s_cyc_o, grant_o, s_adr_o} !== {1'b1, 2'b01, 32'h80}) begin
      miscompares++;
      $display("FAIL hold_regrant: got cyc=%b grant=%b adr=%h, want 1/01/00000080", s_cyc_o, grant_o, s_adr_o);
    end
    wait_resp(0, 40);
    drop_m(0);
    wait_idle(20);
    slv_hold = 0;
  endtask

  task automatic test_timeout();
    int   busy;
    logic got;
    slv_never = 1;
    busy = 0;
    got  = 0;
    @(negedge clk_sys);
    expect_resp(0, 1, 1, 32'h0);
    drive_m(0, 0, 32'h0000_0500, 32'h0, 4'hF);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_sys);
      if (s_cyc_o) busy++;
      if (m0_ack_o | m0_err_o) begin
        got = 1;
        break;
      end
    end
    vectors++;
    if (!got || busy != int'(TMO)) begin
      miscompares++;
      $display("FAIL timeout_cycles: got resp=%b busy=%0d, want 1/%0d", got, busy, TMO);
    end
    drop_m(0);
    wait_idle(10);
    slv_never = 0;
  endtask

  task automatic test_reset_mid();
    int bad;
    slv_lat = 8;
    @(negedge clk_sys);
    drive_m(0, 0, 32'h0000_0700, 32'h0, 4'hF);
    repeat (3) @(negedge clk_sys);
    vectors++;
    if (s_cyc_o !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_busy: got cyc=%b before reset, want 1", s_cyc_o);
    end
    #2;
    rst_n = 0;
    exp0.delete();
    exp1.delete();
    mdl_dat[0] = '0;
    mdl_dat[1] = '0;
    #1;
    vectors++;
    if ({s_cyc_o, s_stb_o, grant_o, m0_dat_o, m1_dat_o} !== 68'd0) begin
      miscompares++;
      $display("FAIL async_reset: got cyc=%b stb=%b grant=%b dat0=%h dat1=%h, want all 0",
               s_cyc_o, s_stb_o, grant_o, m0_dat_o, m1_dat_o);
    end
    drop_m(0);
    @(negedge clk_sys);
    @(negedge clk_sys);
    rst_n = 1;
    bad = 0;
    repeat (12) begin
      @(negedge clk_sys);
      if (w_ack != 2'b00 || w_err != 2'b00) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL reset_no_resp: got %0d response cycles after abort, want 0", bad);
    end
    expect_resp(1, 1, 0, 32'h600 ^ RD_KEY);
    drive_m(1, 0, 32'h0000_0600, 32'h0, 4'hF);
    wait_resp(1, 40);
    drop_m(1);
    wait_idle(10);
  endtask

  initial begin
    mdl_dat[0] = '0;
    mdl_dat[1] = '0;
    test_reset();
    test_single_read();
    test_write_hold();
    test_back_to_back();
    test_ack_hold();
    test_timeout();
    test_reset_mid();
    repeat (3) @(negedge clk_sys);
    vectors++;
    if (exp0.size() + exp1.size() != 0) begin
      miscompares++;
      $display("FAIL final_pending: got %0d/%0d outstanding, want 0/0", exp0.size(), exp1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sdram_wb_arbiter.md
Name: sdram_wb_arbiter

Overview:
- Two-master Wishbone arbiter in front of the single-port SDRAM slave. m0 is the instruction-fetch port; m1 is the data port.
- Grants one master at a time and holds the slave request stable for the whole transfer.
- The slave holds ack high until its cycle is dropped. The arbiter therefore enforces a release phase before the next grant.
- Returns registered read data and a one-cycle ack to the winning master. A watchdog flags a hung slave.

Parameters:
- TIMEOUT, 1023: cycles in BUSY without s_ack_i before abort. 0 disables the watchdog.
- TMR_W, 16: watchdog counter width. TIMEOUT must be < 2^TMR_W.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 Wishbone controls.
- m0_sel_i  in  4  master 0 byte selects.
- m0_adr_i, m0_dat_i  in  32 each  master 0 address and write data.
- m0_dat_o  out  32  master 0 read data, registered.
- m0_ack_o, m0_err_o  out  1 each  master 0 one-cycle completion and timeout pulses.
- m1_*  same set as m0_*, for master 1.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to SDRAM slave.
- s_sel_o  out  4  to SDRAM slave.
- s_adr_o, s_dat_o  out  32 each  to SDRAM slave.
- s_dat_i  in  32  slave read data.
- s_ack_i  in  1  slave ack (level, held until cyc drops).
- grant_o  out  2  one-hot current owner; 00 when idle.

Behaviour:
- Request: reqN = mN_cyc_i & mN_stb_i.
- Reset (async, rst_n_i=0):
  - Outputs: all s_* = 0, mN_ack_o = mN_err_o = 0, mN_dat_o = 0, grant_o = 00.
  - Internal: state = IDLE, timer = 0, last_grant = m1.
  - Takes effect immediately, including mid-transfer. No ack or err is issued for the aborted transfer.
- State machine: IDLE, BUSY, RELEASE.
- IDLE:
  - If any reqN is high, select a winner (see arbitration).
  - Latch the winner's we/sel/adr/dat into slave output registers.
  - Set s_cyc_o = s_stb_o = 1 and grant_o, clear timer, go to BUSY.
  - Slave sees the request 1 cycle after the master's request is sampled.
- BUSY:
  - s_* outputs stay constant; changes on the master inputs are ignored.
  - timer increments each cycle.
  - If s_ack_i = 1:
    - If the transfer is a read, capture s_dat_i into the winner's dat_o.
    - Winner's ack_o = 1 for exactly 1 cycle (the next cycle).
    - Drop s_cyc_o/s_stb_o; go to RELEASE.
  - Else if TIMEOUT != 0 and timer == TIMEOUT-1:
    - Winner's err_o = 1 for exactly 1 cycle.
    - Drop s_cyc_o/s_stb_o; go to RELEASE.
    - dat_o is unchanged.
  - Ack has priority over timeout when both occur in the same cycle.
- RELEASE:
  - grant_o stays at the winner; s_cyc_o = 0.
  - Exit to IDLE only when s_ack_i == 0 AND at least 1 cycle has been spent in RELEASE.
  - This guarantees the master has seen its ack pulse and dropped stb before re-arbitration.
  - On exit, clear grant_o and record last_grant = winner.
- Write data and sel are forwarded unchanged. s_dat_o is don't-care (held) on reads.
- A master dropping cyc mid-BUSY does not abort the slave transfer. The transfer completes and the ack is still pulsed.
- Throughput: minimum turnaround is IDLE(1) + slave latency + RELEASE(≥2) cycles.
- mN_dat_o holds its last read value until the next read completion for that master.

Optional Feature:
- SDRAM_ARB_RR_EN defined: round-robin arbitration.
  - On simultaneous requests, grant the master that is not last_grant.
  - A single requester always wins.
- SDRAM_ARB_RR_EN undefined: fixed priority. m1 (data) always beats m0 on a tie; last_grant is unused.

Test Plan:
- Single m0 read, addr 0x0000_0100, slave acks 8 cycles after s_stb_o with s_dat_i = 0xDEADBEEF → s_adr_o = 0x100 and s_we_o = 0 in BUSY; m0_dat_o = 0xDEADBEEF; m0_ack_o high exactly 1 cycle; grant_o = 01 → 00.
- m1 write, adr 0x200, dat 0x12345678, sel 0011, master changes adr to 0x300 mid-BUSY → slave sees 0x200/0x12345678/0011 throughout; m1_ack_o pulses once.
- Simultaneous m0+m1 requests, both held high for 4 back-to-back transfers:
  - RR build: grants m0, m1, m0, m1.
  - Non-RR build: grants m1 four times, m0 starved.
- Slave holds s_ack_i high 3 cycles after cyc drops → no new s_cyc_o until ack low; pending m0 request granted on the first IDLE cycle after.
- TIMEOUT = 20, slave never acks → m0_err_o pulses at BUSY cycle 20; no ack; m0_dat_o unchanged; returns to IDLE.
- rst_n_i pulsed low mid-BUSY, asynchronous to clk_sys → s_cyc_o and grant_o go 0 immediately; no ack/err; first request after reset served normally.
